// File: rtl/cia_timer_pkg.sv
// Shared constants for the CIA-style interval timer: register map, control
// register bit positions and the latch/counter reset value.
package cia_timer_pkg;

    localparam logic [1:0] ADDR_TLO = 2'd0;
    localparam logic [1:0] ADDR_THI = 2'd1;
    localparam logic [1:0] ADDR_CR  = 2'd2;
    localparam logic [1:0] ADDR_ICR = 2'd3;

    localparam int CR_START   = 0;
    localparam int CR_ONESHOT = 3;
    localparam int CR_LOAD    = 4;
    localparam int CR_INMODE  = 5;

    // LOAD is a strobe and is never stored, so it always reads back as 0.
    localparam logic [7:0] CR_STORE_MASK = 8'hEF;

    localparam logic [15:0] LATCH_INIT_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/cia_timer_counter.sv
// 16-bit loadable down-counter with zero detect; load has priority over
// decrement.
module cia_timer_counter #(
    parameter logic [15:0] INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic [15:0] count,
    output logic        zero
);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            count <= INIT;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/cia_timer.sv
// CIA-8520-style timer A: latch/counter/control registers, underflow pulse
// and maskable interrupt, counting E-clock or external pulses.
module cia_timer
    import cia_timer_pkg::*;
#(
    parameter logic [15:0] LATCH_INIT = LATCH_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       eclk_en,
    input  logic       cnt_en,
    input  logic       wr,
    input  logic       rd,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       underflow,
    output logic       irq
);

    logic [15:0] latch, count, load_val;
    logic [7:0]  cr, rd_mux;
    logic        flag, mask, zero;
    logic        wr_tlo, wr_thi, wr_cr, wr_icr, rd_icr;
    logic        tick, cr_stop, thi_load, force_load, wr_load;
    logic        uf_event, load, dec;

    always_comb begin
        wr_tlo     = wr && (addr == ADDR_TLO);
        wr_thi     = wr && (addr == ADDR_THI);
        wr_cr      = wr && (addr == ADDR_CR);
        wr_icr     = wr && (addr == ADDR_ICR);
        rd_icr     = rd && (addr == ADDR_ICR);
        tick       = cr[CR_START] && (cr[CR_INMODE] ? cnt_en : eclk_en);
        thi_load   = wr_thi && (!cr[CR_START] || cr[CR_ONESHOT]);
        force_load = wr_cr && data_in[CR_LOAD];
        wr_load    = thi_load || force_load;
        cr_stop    = wr_cr && !data_in[CR_START];
        // Register-driven loads and a stopping CR write both swallow a tick.
        uf_event   = tick && !cr_stop && !wr_load && zero;
        dec        = tick && !cr_stop && !wr_load && !zero;
        load       = wr_load || uf_event;
        load_val   = thi_load ? {data_in, latch[7:0]} : latch;
        rd_mux     = 8'h00;
        case (addr)
            ADDR_TLO: rd_mux = count[7:0];
            ADDR_THI: rd_mux = count[15:8];
            ADDR_CR:  rd_mux = cr;
            default:  rd_mux = {flag & mask, 6'b0, flag};
        endcase
    end

    cia_timer_counter #(
        .INIT (LATCH_INIT)
    ) u_counter (
        .clk      (clk),
        ._reset   (_reset),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .count    (count),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            latch     <= LATCH_INIT;
            cr        <= 8'h00;
            flag      <= 1'b0;
            mask      <= 1'b0;
            irq       <= 1'b0;
            underflow <= 1'b0;
            data_out  <= 8'h00;
        end else begin
            if (wr_tlo) latch[7:0]  <= data_in;
            if (wr_thi) latch[15:8] <= data_in;
            if (wr_cr) begin
                cr <= data_in & CR_STORE_MASK;
            end else if (wr_thi && cr[CR_ONESHOT]) begin
                cr[CR_START] <= 1'b1;
            end else if (uf_event && cr[CR_ONESHOT]) begin
                cr[CR_START] <= 1'b0;
            end
            if (wr_icr) begin
                mask <= data_in[7] ? (mask | data_in[0]) : (mask & ~data_in[0]);
            end
            // Underflow set wins over the clear-on-read of ICR.
            if (uf_event) begin
                flag <= 1'b1;
            end else if (rd_icr) begin
                flag <= 1'b0;
            end
            irq       <= flag & mask;
            underflow <= uf_event;
            if (rd) data_out <= rd_mux;
        end
    end

endmodule

// File: tb/tb_cia_timer.sv
// Directed bench for cia_timer: a rule-level model tracked every cycle plus
// literal expectations for each scenario.
module tb_cia_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       eclk_en = 1'b0, cnt_en = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       underflow, irq;

    int n_vec = 0;
    int n_err = 0;
    int uf_cnt = 0;
    int eclk_div = 0;
    bit eclk_auto = 1'b0;
    bit chk_en = 1'b0;

    logic [15:0] m_latch, m_count;
    logic [7:0]  m_cr, m_dout;
    logic        m_flag, m_mask, m_irq, m_uf, m_dout_vld;

    always #5 clk = ~clk;

    cia_timer dut (
        .clk       (clk),
        ._reset    (rst_n),
        .eclk_en   (eclk_en),
        .cnt_en    (cnt_en),
        .wr        (wr),
        .rd        (rd),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .underflow (underflow),
        .irq       (irq)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_latch = 16'hFFFF; m_count = 16'hFFFF; m_cr = 8'h00;
        m_flag = 1'b0; m_mask = 1'b0; m_irq = 1'b0; m_uf = 1'b0;
        m_dout = 8'h00; m_dout_vld = 1'b1;
    endtask

    // One clock of timer behaviour, applied from the register-level rules.
    task automatic model_step();
        logic tick, wload, stop, uf, set_start, cr_wr;
        logic [15:0] n_count, n_latch;
        logic [7:0] n_cr;
        logic n_flag, n_mask;
        n_count = m_count; n_latch = m_latch; n_cr = m_cr;
        n_flag = m_flag; n_mask = m_mask;
        wload = 0; stop = 0; uf = 0; set_start = 0; cr_wr = 0;
        tick = m_cr[0] && (m_cr[5] ? cnt_en : eclk_en);
        if (wr) begin
            case (addr)
                2'd0: n_latch[7:0] = data_in;
                2'd1: begin
                    n_latch[15:8] = data_in;
                    if (!m_cr[0] || m_cr[3]) begin
                        n_count = {data_in, m_latch[7:0]};
                        wload = 1;
                    end
                    set_start = m_cr[3];
                end
                2'd2: begin
                    cr_wr = 1;
                    stop = !data_in[0];
                    if (data_in[4]) begin
                        n_count = m_latch;
                        wload = 1;
                    end
                end
                default: n_mask = data_in[7] ? (m_mask | data_in[0]) : (m_mask & ~data_in[0]);
            endcase
        end
        if (tick && !stop && !wload) begin
            if (m_count == 16'd0) begin
                uf = 1;
                n_count = m_latch;
                if (m_cr[3]) n_cr[0] = 1'b0;
            end else begin
                n_count = m_count - 16'd1;
            end
        end
        if (set_start) n_cr[0] = 1'b1;
        if (cr_wr) n_cr = {data_in[7:5], 1'b0, data_in[3:0]};
        m_dout_vld = rd;
        if (rd) begin
            case (addr)
                2'd0: m_dout = m_count[7:0];
                2'd1: m_dout = m_count[15:8];
                2'd2: m_dout = m_cr;
                default: m_dout = {m_flag & m_mask, 6'b0, m_flag};
            endcase
            if (addr == 2'd3) n_flag = 1'b0;
        end
        if (uf) n_flag = 1'b1;
        m_irq = m_flag & m_mask;
        m_uf = uf;
        m_count = n_count; m_latch = n_latch; m_cr = n_cr;
        m_flag = n_flag; m_mask = n_mask;
    endtask

    task automatic cycle();
        if (eclk_auto) begin
            eclk_en = (eclk_div == 0);
            eclk_div = (eclk_div + 1) % 10;
        end
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        if (underflow) uf_cnt++;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; data_in = d;
        cycle();
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
        rd = 1'b1; addr = a;
        cycle();
        rd = 1'b0;
        d = data_out;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd_reg(a, d);
        check(name, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic tick_e();
        eclk_en = 1'b1; cycle(); eclk_en = 1'b0;
    endtask

    task automatic tick_c();
        cnt_en = 1'b1; cycle(); cnt_en = 1'b0;
    endtask

    task automatic run_auto(input int n);
        eclk_auto = 1'b1; eclk_div = 0;
        repeat (n) cycle();
        eclk_auto = 1'b0; eclk_en = 1'b0;
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("underflow", {15'b0, underflow}, {15'b0, m_uf});
                check("irq", {15'b0, irq}, {15'b0, m_irq});
                if (m_dout_vld) check("data_out", {8'h00, data_out}, {8'h00, m_dout});
            end
        end
    end

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (3) cycle();
        check("reset_dout", {8'h00, data_out}, 16'h0000);
        check("reset_uf", {15'b0, underflow}, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        rst_n = 1'b1;
        cycle();
        rd_chk("reset_tlo", 2'd0, 8'hFF);
        rd_chk("reset_thi", 2'd1, 8'hFF);
        rd_chk("reset_cr", 2'd2, 8'h00);

        // Continuous mode, latch = 3: sequence 3,2,1,0 then underflow reload.
        wr_reg(2'd0, 8'h03);
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd2, 8'h01);
        rd_chk("cont_cnt3", 2'd0, 8'h03);
        tick_e(); rd_chk("cont_cnt2", 2'd0, 8'h02);
        tick_e(); rd_chk("cont_cnt1", 2'd0, 8'h01);
        tick_e(); rd_chk("cont_cnt0", 2'd0, 8'h00);
        tick_e();
        check("cont_uf_pulse", {15'b0, underflow}, 16'h0001);
        rd_chk("cont_reload", 2'd0, 8'h03);
        rd_chk("cont_flag", 2'd3, 8'h01);
        uf_cnt = 0;
        run_auto(120);
        check("cont_uf_count", uf_cnt[15:0], 16'd3);
        wr_reg(2'd2, 8'h00);

        // One-shot with auto-start from the THI write.
        wr_reg(2'd2, 8'h08);
        wr_reg(2'd0, 8'h05);
        wr_reg(2'd1, 8'h00);
        rd_chk("os_started", 2'd2, 8'h09);
        uf_cnt = 0;
        repeat (9) tick_e();
        check("os_uf_count", uf_cnt[15:0], 16'd1);
        rd_chk("os_stopped", 2'd2, 8'h08);
        rd_chk("os_tlo", 2'd0, 8'h05);
        rd_chk("os_thi", 2'd1, 8'h00);
        rd_chk("os_flag", 2'd3, 8'h01);

        // Force load coincident with a tick: load wins.
        wr_reg(2'd2, 8'h00);
        wr_reg(2'd0, 8'h10);
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd2, 8'h01);
        wr_reg(2'd0, 8'h34);
        wr_reg(2'd1, 8'h12);
        rd_chk("fl_hold", 2'd0, 8'h10);
        eclk_en = 1'b1;
        wr_reg(2'd2, 8'h11);
        eclk_en = 1'b0;
        rd_chk("fl_tlo", 2'd0, 8'h34);
        rd_chk("fl_thi", 2'd1, 8'h12);
        rd_chk("fl_cr", 2'd2, 8'h01);
        wr_reg(2'd2, 8'hC0);
        rd_chk("cr_other_bits", 2'd2, 8'hC0);
        wr_reg(2'd2, 8'h00);

        // Interrupt path and read/underflow collision.
        wr_reg(2'd3, 8'h81);
        wr_reg(2'd0, 8'h01);
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd2, 8'h01);
        tick_e();
        tick_e();
        check("int_uf", {15'b0, underflow}, 16'h0001);
        check("int_irq_lag", {15'b0, irq}, 16'h0000);
        cycle();
        check("int_irq_set", {15'b0, irq}, 16'h0001);
        rd_chk("int_icr", 2'd3, 8'h81);
        cycle();
        check("int_irq_clr", {15'b0, irq}, 16'h0000);
        tick_e();
        eclk_en = 1'b1;
        rd_chk("int_rd_collide", 2'd3, 8'h00);
        eclk_en = 1'b0;
        check("int_collide_uf", {15'b0, underflow}, 16'h0001);
        rd_chk("int_flag_kept", 2'd3, 8'h81);
        wr_reg(2'd2, 8'h00);

        // External count source ignores eclk_en.
        wr_reg(2'd0, 8'h01);
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd2, 8'h21);
        uf_cnt = 0;
        repeat (5) tick_e();
        rd_chk("ext_hold", 2'd0, 8'h01);
        check("ext_no_uf", uf_cnt[15:0], 16'd0);
        tick_c();
        cycle();
        tick_c();
        cycle();
        check("ext_uf_count", uf_cnt[15:0], 16'd1);

        // Asynchronous reset in the middle of counting.
        wr_reg(2'd2, 8'h01);
        run_auto(25);
        rd_chk("pre_reset_cr", 2'd2, 8'h01);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("areset_dout", {8'h00, data_out}, 16'h0000);
        check("areset_uf", {15'b0, underflow}, 16'h0000);
        check("areset_irq", {15'b0, irq}, 16'h0000);
        repeat (3) cycle();
        rst_n = 1'b1;
        uf_cnt = 0;
        run_auto(50);
        check("post_reset_no_uf", uf_cnt[15:0], 16'd0);
        rd_chk("post_reset_tlo", 2'd0, 8'hFF);
        rd_chk("post_reset_thi", 2'd1, 8'hFF);
        rd_chk("post_reset_cr", 2'd2, 8'h00);
        rd_chk("post_reset_icr", 2'd3, 8'h00);

        cycle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
